// File: rtl/riscv_types.sv
// Shared core types: the execution-unit writeback bundle and FP pipe limits.
package riscv_types;

    localparam int FP_PIPE_MAX_DEPTH = 8;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
        logic [2:0] wb_sel;
        logic [4:0] fflags;
        logic [7:0] rob_tag;
    } exe_p_mux_bus_type;

endpackage

// File: rtl/fp_rd_match.sv
// One pipeline stage's destination compared against the three issue sources.
// x0 is hardwired zero in the integer file, so it never creates a dependency.
module fp_rd_match (
    input  logic       valid,
    input  logic [4:0] rd,
    input  logic       reg_write,
    input  logic       fp_reg_write,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rs3,
    input  logic [2:0] rs_is_fp,
    input  logic [2:0] rs_used,
    output logic       match
);

    logic [2:0][4:0] rs;

    assign rs = {rs3, rs2, rs1};

    // OR of per-source hits; FP sources compare against FP writes only
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (valid && rs_used[i] && (rd == rs[i])) begin
                if (rs_is_fp[i] && fp_reg_write) begin
                    match = 1'b1;
                end
                if (!rs_is_fp[i] && reg_write && (rs[i] != 5'd0)) begin
                    match = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_pipe_ctrl.sv
// Valid/sideband pipeline for multi-cycle FP units. Moves in lock-step with the
// datapath registers, whose load/clear strobes it also generates, and reports
// in-flight destinations plus a RAW hazard flag for the issue stage.
module fp_pipe_ctrl
    import riscv_types::*;
#(
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DEPTH-1:0]        clear,
    input  logic                    p_start,
    input  exe_p_mux_bus_type       pipeline_signals_i,
    output logic                    p_result,
    output exe_p_mux_bus_type       pipeline_signals_o,
    output logic [DEPTH-1:0]        stage_ld,
    output logic [DEPTH-1:0]        stage_clr,
    output logic [0:DEPTH-1][4:0]   uu_rd,
    output logic [DEPTH-1:0]        uu_reg_write,
    output logic [DEPTH-1:0]        uu_FP_reg_write,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [4:0]              rs3,
    input  logic [2:0]              rs_is_fp,
    input  logic [2:0]              rs_used,
    output logic                    raw_hazard,
    output logic                    busy,
    output logic [CNT_W-1:0]        in_flight
);

    logic [DEPTH-1:0]              valid_q;
    exe_p_mux_bus_type [DEPTH-1:0] bus_q;
    logic [DEPTH-1:0]              match;
    logic [CNT_W-1:0]              count;

    // Clear beats advance so a flushed datapath register never loads garbage.
    assign stage_clr = clear;
    assign stage_ld  = {DEPTH{en}} & ~clear;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              prev_valid;
        exe_p_mux_bus_type prev_bus;
        logic              v_q;
        exe_p_mux_bus_type b_q;

        if (k == 0) begin : g_head
            assign prev_valid = p_start;
            assign prev_bus   = pipeline_signals_i;
        end else begin : g_body
            // Pre-clear value of the predecessor: a stage cleared this edge
            // still hands its token forward.
            assign prev_valid = valid_q[k-1];
            assign prev_bus   = bus_q[k-1];
        end

        // Stage register: reset > clear > advance > hold
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= 1'b0;
                b_q <= '0;
            end else if (clear[k]) begin
                v_q <= 1'b0;
                b_q <= '0;
            end else if (en) begin
                v_q <= prev_valid;
                b_q <= prev_bus;
            end
        end

        assign valid_q[k]         = v_q;
        assign bus_q[k]           = b_q;
        assign uu_rd[k]           = v_q ? b_q.rd : 5'd0;
        assign uu_reg_write[k]    = v_q & b_q.reg_write;
        assign uu_FP_reg_write[k] = v_q & b_q.FP_reg_write;

        fp_rd_match u_match (
            .valid        (v_q),
            .rd           (b_q.rd),
            .reg_write    (b_q.reg_write),
            .fp_reg_write (b_q.FP_reg_write),
            .rs1          (rs1),
            .rs2          (rs2),
            .rs3          (rs3),
            .rs_is_fp     (rs_is_fp),
            .rs_used      (rs_used),
            .match        (match[k])
        );
    end

    // Popcount of valid stages
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    assign in_flight          = count;
    assign busy               = |valid_q;
    assign raw_hazard         = |match;
    assign p_result           = valid_q[DEPTH-1];
    assign pipeline_signals_o = bus_q[DEPTH-1];

endmodule

// File: tb/tb_fp_pipe_ctrl.sv
// Bench for fp_pipe_ctrl at DEPTH 1, 3 and 8 sharing one stimulus stream,
// checked every cycle against an array-based model plus directed cases.
module tb_fp_pipe_ctrl;
    import riscv_types::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              p_start = 1'b0;
    logic [7:0]        clr8 = 8'd0;
    exe_p_mux_bus_type bus_in = '0;
    logic [4:0]        rs1 = 5'd0, rs2 = 5'd0, rs3 = 5'd0;
    logic [2:0]        rs_is_fp = 3'd0, rs_used = 3'd0;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    logic m1_pres, m3_pres, m8_pres;
    exe_p_mux_bus_type m1_bus, m3_bus, m8_bus;
    logic [0:0] m1_ld, m1_clr, m1_uw, m1_uf;
    logic [2:0] m3_ld, m3_clr, m3_uw, m3_uf;
    logic [7:0] m8_ld, m8_clr, m8_uw, m8_uf;
    logic [0:0][4:0] m1_urd;
    logic [0:2][4:0] m3_urd;
    logic [0:7][4:0] m8_urd;
    logic m1_haz, m3_haz, m8_haz, m1_busy, m3_busy, m8_busy;
    logic [0:0] m1_inf;
    logic [1:0] m3_inf;
    logic [3:0] m8_inf;

    fp_pipe_ctrl #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .clear(clr8[0:0]), .p_start(p_start),
        .pipeline_signals_i(bus_in), .p_result(m1_pres), .pipeline_signals_o(m1_bus),
        .stage_ld(m1_ld), .stage_clr(m1_clr), .uu_rd(m1_urd), .uu_reg_write(m1_uw),
        .uu_FP_reg_write(m1_uf), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rs_is_fp(rs_is_fp),
        .rs_used(rs_used), .raw_hazard(m1_haz), .busy(m1_busy), .in_flight(m1_inf)
    );

    fp_pipe_ctrl #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .clear(clr8[2:0]), .p_start(p_start),
        .pipeline_signals_i(bus_in), .p_result(m3_pres), .pipeline_signals_o(m3_bus),
        .stage_ld(m3_ld), .stage_clr(m3_clr), .uu_rd(m3_urd), .uu_reg_write(m3_uw),
        .uu_FP_reg_write(m3_uf), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rs_is_fp(rs_is_fp),
        .rs_used(rs_used), .raw_hazard(m3_haz), .busy(m3_busy), .in_flight(m3_inf)
    );

    fp_pipe_ctrl #(.DEPTH(8)) u_d8 (
        .clk(clk), .rst(rst), .en(en), .clear(clr8), .p_start(p_start),
        .pipeline_signals_i(bus_in), .p_result(m8_pres), .pipeline_signals_o(m8_bus),
        .stage_ld(m8_ld), .stage_clr(m8_clr), .uu_rd(m8_urd), .uu_reg_write(m8_uw),
        .uu_FP_reg_write(m8_uf), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rs_is_fp(rs_is_fp),
        .rs_used(rs_used), .raw_hazard(m8_haz), .busy(m8_busy), .in_flight(m8_inf)
    );

    // Flattened uu_rd views, stage k at bits [5k +: 5]
    logic [39:0] urd1, urd3, urd8;
    always_comb begin
        urd1 = '0;
        urd3 = '0;
        urd8 = '0;
        urd1[4:0] = m1_urd[0];
        for (int k = 0; k < 3; k++) urd3[k*5 +: 5] = m3_urd[k];
        for (int k = 0; k < 8; k++) urd8[k*5 +: 5] = m8_urd[k];
    end

    // Reference model: per instance, an array of stage contents
    int dep[3] = '{1, 3, 8};
    bit mv[3][8];
    exe_p_mux_bus_type mb[3][8];

    // Model update at each edge, from the values the stages held before it
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (!rst || clr8[k]) begin
                    mv[i][k] <= 1'b0;
                    mb[i][k] <= '0;
                end else if (en && k < dep[i]) begin
                    mv[i][k] <= (k == 0) ? p_start : mv[i][k-1];
                    mb[i][k] <= (k == 0) ? bus_in : mb[i][k-1];
                end
            end
        end
    end

    function automatic bit model_hazard(int i);
        logic [4:0] rs_v[3];
        bit hit;
        rs_v = '{rs1, rs2, rs3};
        hit = 1'b0;
        for (int k = 0; k < dep[i]; k++) begin
            for (int s = 0; s < 3; s++) begin
                if (mv[i][k] && rs_used[s] && mb[i][k].rd == rs_v[s]) begin
                    if (rs_is_fp[s] && mb[i][k].FP_reg_write) hit = 1'b1;
                    if (!rs_is_fp[s] && mb[i][k].reg_write && rs_v[s] != 5'd0) hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i, input logic pres, input exe_p_mux_bus_type bus,
                            input logic haz, input logic bsy, input int inf,
                            input logic [7:0] ld, input logic [7:0] cl, input logic [39:0] urd,
                            input logic [7:0] uw, input logic [7:0] uf);
        int d;
        int cnt;
        logic [7:0] e_ld, e_cl, e_uw, e_uf;
        logic [39:0] e_urd;
        d = dep[i];
        cnt = 0;
        e_ld = '0; e_cl = '0; e_uw = '0; e_uf = '0; e_urd = '0;
        for (int k = 0; k < d; k++) begin
            if (mv[i][k]) begin
                cnt++;
                e_urd[k*5 +: 5] = mb[i][k].rd;
                e_uw[k] = mb[i][k].reg_write;
                e_uf[k] = mb[i][k].FP_reg_write;
            end
            e_ld[k] = en & ~clr8[k];
            e_cl[k] = clr8[k];
        end
        check($sformatf("p_result_d%0d", d), 64'(pres), 64'(mv[i][d-1]));
        check($sformatf("bus_out_d%0d", d), 64'(bus), 64'(mb[i][d-1]));
        check($sformatf("in_flight_d%0d", d), 64'(inf), 64'(cnt));
        check($sformatf("busy_d%0d", d), 64'(bsy), 64'(cnt != 0));
        check($sformatf("raw_hazard_d%0d", d), 64'(haz), 64'(model_hazard(i)));
        check($sformatf("stage_ld_d%0d", d), 64'(ld), 64'(e_ld));
        check($sformatf("stage_clr_d%0d", d), 64'(cl), 64'(e_cl));
        check($sformatf("uu_rd_d%0d", d), 64'(urd), 64'(e_urd));
        check($sformatf("uu_reg_write_d%0d", d), 64'(uw), 64'(e_uw));
        check($sformatf("uu_FP_reg_write_d%0d", d), 64'(uf), 64'(e_uf));
    endtask

    // Per-cycle compare, mid-cycle away from the active edge and input changes
    always @(negedge clk) begin
        if (chk_on) begin
            chk_inst(0, m1_pres, m1_bus, m1_haz, m1_busy, int'(m1_inf), 8'(m1_ld), 8'(m1_clr), urd1, 8'(m1_uw), 8'(m1_uf));
            chk_inst(1, m3_pres, m3_bus, m3_haz, m3_busy, int'(m3_inf), 8'(m3_ld), 8'(m3_clr), urd3, 8'(m3_uw), 8'(m3_uf));
            chk_inst(2, m8_pres, m8_bus, m8_haz, m8_busy, int'(m8_inf), 8'(m8_ld), 8'(m8_clr), urd8, m8_uw, m8_uf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        en = 1'b1;
        p_start = 1'b0;
        bus_in = '0;
        clr8 = 8'hFF;
        tick();
        clr8 = 8'h00;
    endtask

    function automatic exe_p_mux_bus_type mk_bus(input logic [4:0] rd, input logic rw, input logic fw);
        exe_p_mux_bus_type b;
        b = '0;
        b.rd = rd;
        b.reg_write = rw;
        b.FP_reg_write = fw;
        b.rob_tag = 8'(rd) + 8'h40;
        return b;
    endfunction

    int got_rd[$];
    int got_idx[$];
    logic [31:0] r;

    initial begin
        // Reset state, before any clock edge
        #3;
        check("reset_p_result", 64'(m3_pres), 64'd0);
        check("reset_in_flight", 64'(m3_inf), 64'd0);
        check("reset_busy", 64'(m3_busy), 64'd0);
        check("reset_raw_hazard", 64'(m3_haz), 64'd0);
        check("reset_bus_out", 64'(m3_bus), 64'd0);
        check("reset_uu_rd", 64'(urd3), 64'd0);
        chk_on = 1'b1;
        tick();
        rst = 1'b1;

        // Single token latency across all three depths
        drain();
        bus_in = mk_bus(5'd5, 1'b0, 1'b1);
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        bus_in = '0;
        for (int t = 1; t <= 9; t++) begin
            #1;
            check($sformatf("lat_d1_t%0d", t), 64'(m1_pres), 64'(t == 1));
            check($sformatf("lat_d3_t%0d", t), 64'(m3_pres), 64'(t == 3));
            check($sformatf("lat_d8_t%0d", t), 64'(m8_pres), 64'(t == 8));
            check($sformatf("lat_inf_d3_t%0d", t), 64'(m3_inf), 64'(t <= 3));
            if (t == 3) check("lat_rd_d3", 64'(m3_bus.rd), 64'd5);
            if (t == 8) check("lat_rd_d8", 64'(m8_bus.rd), 64'd5);
            tick();
        end

        // Back-to-back tokens with a two-cycle stall in the middle
        drain();
        for (int idx = 0; idx < 10; idx++) begin
            en = !(idx == 2 || idx == 3);
            p_start = (idx == 0 || idx == 1 || idx == 4);
            bus_in = (idx == 0) ? mk_bus(5'd1, 1'b1, 1'b0) :
                     (idx == 1) ? mk_bus(5'd2, 1'b1, 1'b0) :
                     (idx == 4) ? mk_bus(5'd3, 1'b1, 1'b0) : '0;
            #1;
            if (m3_pres && en) begin
                got_rd.push_back(int'(m3_bus.rd));
                got_idx.push_back(idx);
            end
            tick();
        end
        check("stall_token_count", 64'(got_rd.size()), 64'd3);
        if (got_rd.size() == 3) begin
            check("stall_rd0", 64'(got_rd[0]), 64'd1);
            check("stall_rd1", 64'(got_rd[1]), 64'd2);
            check("stall_rd2", 64'(got_rd[2]), 64'd3);
            check("stall_cyc0", 64'(got_idx[0]), 64'd5);
            check("stall_cyc1", 64'(got_idx[1]), 64'd6);
            check("stall_cyc2", 64'(got_idx[2]), 64'd7);
        end

        // Clear the middle stage while stalled
        drain();
        for (int j = 4; j <= 6; j++) begin
            p_start = 1'b1;
            bus_in = mk_bus(5'(j), 1'b1, 1'b0);
            tick();
        end
        p_start = 1'b0;
        bus_in = '0;
        en = 1'b0;
        #1;
        check("clr_inf_before", 64'(m3_inf), 64'd3);
        clr8 = 8'b0000_0010;
        tick();
        clr8 = 8'd0;
        #1;
        check("clr_inf_after", 64'(m3_inf), 64'd2);
        check("clr_uu_rd0", 64'(m3_urd[0]), 64'd6);
        check("clr_uu_rd1", 64'(m3_urd[1]), 64'd0);
        check("clr_uu_rd2", 64'(m3_urd[2]), 64'd4);
        tick();

        // FP destination in stage 1 against rs2
        drain();
        p_start = 1'b1;
        bus_in = mk_bus(5'd7, 1'b0, 1'b1);
        tick();
        p_start = 1'b0;
        bus_in = '0;
        tick();
        en = 1'b0;
        rs1 = 5'd0; rs2 = 5'd7; rs3 = 5'd0;
        rs_is_fp = 3'b010;
        rs_used = 3'b010;
        #1;
        check("haz_fp_rs2", 64'(m3_haz), 64'd1);
        rs_is_fp = 3'b000;
        #1;
        check("haz_int_rs2_vs_fp", 64'(m3_haz), 64'd0);
        tick();

        // Integer x0 destination never hazards
        drain();
        p_start = 1'b1;
        bus_in = mk_bus(5'd0, 1'b1, 1'b0);
        tick();
        p_start = 1'b0;
        bus_in = '0;
        en = 1'b0;
        rs1 = 5'd0; rs2 = 5'd9; rs3 = 5'd9;
        rs_is_fp = 3'b000;
        rs_used = 3'b001;
        #1;
        check("haz_x0", 64'(m3_haz), 64'd0);
        check("haz_x0_valid", 64'(m3_inf), 64'd1);
        rs_used = 3'b000;
        tick();

        // Asynchronous reset with the pipe full, then first token after release
        drain();
        for (int j = 9; j <= 11; j++) begin
            p_start = 1'b1;
            bus_in = mk_bus(5'(j), 1'b1, 1'b1);
            tick();
        end
        p_start = 1'b0;
        bus_in = '0;
        #1;
        check("rst_inf_before", 64'(m3_inf), 64'd3);
        rst = 1'b0;
        #1;
        check("rst_async_p_result", 64'(m3_pres), 64'd0);
        check("rst_async_in_flight", 64'(m3_inf), 64'd0);
        check("rst_async_busy", 64'(m3_busy), 64'd0);
        check("rst_async_uu_rd", 64'(urd3), 64'd0);
        check("rst_async_bus_d8", 64'(m8_bus), 64'd0);
        tick();
        rst = 1'b1;
        en = 1'b1;
        p_start = 1'b1;
        bus_in = mk_bus(5'd12, 1'b1, 1'b0);
        tick();
        p_start = 1'b0;
        bus_in = '0;
        #1;
        check("post_rst_inf", 64'(m3_inf), 64'd1);
        check("post_rst_rd0", 64'(m3_urd[0]), 64'd12);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            en = ($urandom_range(0, 7) != 0);
            p_start = $urandom_range(0, 1) == 1;
            r = $urandom;
            bus_in = r[22:0];
            bus_in.rd = 5'($urandom_range(0, 7));
            clr8 = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'd0;
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rs3 = 5'($urandom_range(0, 7));
            rs_is_fp = 3'($urandom);
            rs_used = 3'($urandom);
            rst = ($urandom_range(0, 299) != 0);
        end
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
